// File: rtl/test_unit.sv
// 3-stage pipelined accumulator: fetch (ir/v1), execute (acc), writeback (out).
// Latency: the effect of `in` captured at edge k is visible on `out` after edge k+2.
// Backpressure: none; one instruction accepted every cycle, no stalls or bubbles.
`timescale 1ns/1ps
`default_nettype none

module test_unit #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       in,
  output logic [WIDTH-1:0] out
);

  // Instruction fields: bit 2 selects the operation, bits 1:0 are the immediate.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_XOR = 1'b1;

  logic [2:0]       ir;
  logic             v1;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] acc_next;

  // Immediate zero-extended to the accumulator width.
  assign imm_ext = {{(WIDTH-2){1'b0}}, ir[1:0]};

  // Execute-stage result; a bubble (v1=0) leaves the accumulator untouched.
  always_comb begin
    acc_next = acc;
    if (v1) begin
      case (ir[2])
        OP_ADD:  acc_next = acc + imm_ext;   // wraps modulo 2**WIDTH, no carry kept
        OP_XOR:  acc_next = acc ^ imm_ext;
        default: acc_next = acc;
      endcase
    end
  end

  // Fetch stage: capture the instruction every cycle once out of reset.
  // v1 only gates the very first execute edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir <= 3'b000;
      v1 <= 1'b0;
    end else begin
      ir <= in;
      v1 <= 1'b1;
    end
  end

  // Execute stage: the single owner of acc, so back-to-back dependent
  // instructions always see the previous result without forwarding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end

  // Writeback stage: out is a pure register, so it only moves on a clock
  // edge or on reset assertion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
    end else begin
      out <= acc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_test_unit.sv
`timescale 1ns/1ps

module tb_test_unit;

  logic       clk;
  logic       rst;
  logic [2:0] in;
  logic [2:0] out;

  int checks;
  int errors;

  // Reference model: out after the n-th edge since reset release equals the
  // fold of the first n-2 captured instructions over an accumulator starting at 0.
  logic [2:0] hist[$];
  int         n_edges;
  int         macc;

  test_unit #(.WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the stimulus is linear, but never allow a hang.
  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    n_edges = 0;
    macc    = 0;
  endtask

  task automatic model_edge(input logic [2:0] v);
    logic [2:0] ins;
    hist.push_back(v);
    n_edges++;
    if (n_edges >= 3) begin
      ins = hist[n_edges-3];
      if (ins[2]) macc = macc ^ int'(ins[1:0]);
      else        macc = (macc + int'(ins[1:0])) % 8;
    end
  endtask

  // One operating cycle: drive, clock, update model, check just after the edge.
  task automatic tick(input string tag, input logic [2:0] v);
    in = v;
    @(posedge clk);
    model_edge(v);
    #1;
    check(tag, out, 3'(macc));
  endtask

  // One cycle with reset held: out must stay 0 regardless of in.
  task automatic rst_tick(input string tag, input logic [2:0] v);
    in = v;
    @(posedge clk);
    #1;
    check(tag, out, 3'b000);
  endtask

  // Release reset away from the clock edge; pipeline restarts empty.
  task automatic release_rst();
    rst = 1'b1;
    model_clear();
  endtask

  // Asynchronous assert mid-cycle: out must clear before the next edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check(tag, out, 3'b000);
  endtask

  initial begin
    logic [2:0] pat[3];
    checks = 0;
    errors = 0;
    model_clear();
    rst = 1'b0;
    in  = 3'b000;
    #1;
    check("reset_initial", out, 3'b000);

    // Long reset with toggling and unknown input.
    pat[0] = 3'b010; pat[1] = 3'b011; pat[2] = 3'bxxx;
    for (int i = 0; i < 22; i++) rst_tick("reset_hold", pat[i % 3]);

    // Single ADD 2 then NOPs: out becomes 2 and stays.
    release_rst();
    tick("add2_single", 3'b010);
    for (int i = 0; i < 5; i++) tick("add2_then_nop", 3'b000);

    // Held ADD 3 from a clean start: 3,6,1,4,7,2...
    rst = 1'b0;
    rst_tick("reset_between", 3'b011);
    release_rst();
    for (int i = 0; i < 9; i++) tick("add3_held", 3'b011);

    // ADD 2, ADD 3, XOR 1 -> 2,5,4.
    rst = 1'b0;
    rst_tick("reset_between", 3'b000);
    release_rst();
    tick("seq_add2", 3'b010);
    tick("seq_add3", 3'b011);
    tick("seq_xor1", 3'b101);
    for (int i = 0; i < 3; i++) tick("seq_tail", 3'b100);

    // Reset mid-stream while out=6, then release with NOPs.
    rst = 1'b0;
    rst_tick("reset_between", 3'b000);
    release_rst();
    for (int i = 0; i < 4; i++) tick("pre_midreset", 3'b011);
    check("out_is_6", out, 3'b110);
    async_reset("midreset_async_clear");
    rst_tick("midreset_hold", 3'b011);
    release_rst();
    for (int i = 0; i < 5; i++) tick("after_midreset_nop", 3'b000);

    // XOR 3 held: 3,0,3,0...
    for (int i = 0; i < 12; i++) tick("xor3_held", 3'b111);

    // Randomized stream with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_reset("rand_async_clear");
        for (int j = 0; j < int'($urandom_range(1, 3)); j++)
          rst_tick("rand_reset_hold", ($urandom_range(0, 1) == 0) ? 3'bxxx : 3'($urandom_range(0, 7)));
        release_rst();
      end
      tick("rand", 3'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
